alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage directly upstream of the 16-bit ALU. Accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8×16 register file, and drives the ALU's operand and one-hot operation inputs from registers. It captures the ALU's registered result two edges after issue and writes it back. RAW hazards are handled with a one-stage scoreboard stall plus a forwarding path from the ALU result.

## Interface
- DATA_W, 16, operand/result width; fixed, since the ALU is 16-bit.
- REGS, 8, register-file depth.
- ADDR_W, 3, register address width; must equal log2(REGS).
- iClock  in  1  sole clock; everything is rising-edge.
- iReset_n  in  1  asynchronous, active-low reset; clears all state.
- iInstrValid  in  1  instruction present on iInstr.
- iInstr  in  16  instruction word; see Operation.
- oInstrReady  out  1  instruction accepted at this edge if iInstrValid is also high.
- oOperandA  out  16  registered; to ALU operand A.
- oOperandB  out  16  registered; to ALU operand B.
- oOperation  out  8  registered one-hot ALU op; 8'h00 when idle.
- iAluResult  in  16  ALU registered result.
- oIllegal  out  1  registered one-cycle pulse when an illegal opcode is accepted.
- oBusy  out  1  E1 or E2 valid.
- iDbgAddr  in  3  debug read address.
- oDbgData  out  16  combinational regfile[iDbgAddr]; committed state only, no bypass.

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
- LDI uses [7:0] as imm, zero-extended.
- Opcode map:
  - 0 ADD (8'h01)
  - 1 AND (8'h02)
  - 2 OR (8'h04)
  - 3 NOT (8'h08; rb not a source)
  - 4 XOR (8'h10)
  - 5 SL (8'h20)
  - 6 SR (8'h40)
  - 7 CMP (8'h80)
  - 8 LDI: issued as OR with A={8'h00,imm}, B=0; no sources
  - 9–15 illegal.
- Pipeline:
  - E1 is the issue registers: operands, op, rd, valid.
  - E2 is the ALU stage tag: rd, valid.
  - Writeback: regfile[E2.rd] <= iAluResult when E2 valid.
- Handshake:
  - Transfer occurs when iInstrValid && oInstrReady at a rising edge.
  - oInstrReady is combinational from iInstr and the pipeline tags.
  - Upstream holds iInstr stable while valid and not ready.
- Hazard rule:
  - oInstrReady = 0 iff the presented legal instruction has a source (ra; rb unless NOT/LDI) equal to E1.rd with E1 valid.
  - Otherwise oInstrReady = 1.
- Forwarding: a source equal to E2.rd with E2 valid reads iAluResult instead of regfile. This forward takes priority over the regfile read.
- Without an accepted legal instruction, E1 valid is cleared and oOperation is 8'h00; operand registers hold their values.
- An illegal opcode is accepted, allocates no pipeline slot, and pulses oIllegal on the following cycle.
- Write-after-write is in order; no special handling.

## Timing
- Reset (iReset_n low, async) clears:
  - all outputs to 0
  - E1/E2 valid
  - all 8 registers to 16'h0000
  - oInstrReady reads 1 once reset deasserts.
- Reset mid-operation discards in-flight instructions; no writeback occurs.
- Issue latency: accepted at edge T, operands and op visible after T; ALU captures at T+1; regfile written at T+2.
- A dependent instruction presented right after its producer sees one stall cycle (ready low), then is accepted at T+2 with the operand forwarded.
- An independent instruction can be accepted every cycle; throughput is 1/cycle.
- oBusy falls the cycle after the last writeback edge.

## Test plan
- Reset: assert iReset_n low mid-cycle -> all outputs 0 immediately. oDbgData = 0 for all addresses after release.
- Dependent chain:
  - Stimulus: LDI r1,0x12; LDI r2,0x34 (back-to-back); then ADD r3,r1,r2.
  - Response: ready low for exactly 1 cycle on the ADD, with r2 forwarded; r3 = 16'h0046; oOperation = 8'h01 on issue.
- CMP: r1 = r4 = 0x0012, CMP r5,r1,r4 -> r5 = 16'h0001. With r4 = 0x0013 -> r5 = 16'h0000.
- Shift boundary: r6 = 16, SL r7,r1,r6 -> r7 = 16'h0000. NOT r0,r1 with r1 = 0x0012 -> r0 = 16'hFFED and no stall on rb.
- Illegal: opcode 0xF with valid -> ready high, oIllegal high for exactly 1 cycle, no regfile change, oOperation = 8'h00.
- Reset mid-flight: assert reset one cycle after issuing ADD r3 -> r3 stays 0, E1/E2 cleared, oBusy = 0.

Source files
------------

// File: rtl/alu_issue.sv
// Decode/issue stage for the 16-bit ALU: 8x16 regfile, E1 issue registers, E2 writeback tag.
// Issue 1 edge, writeback 2 edges after accept; ready drops for one cycle on a RAW against E1.
module alu_issue #(
   parameter int DATA_W = 16,
   parameter int REGS   = 8,
   parameter int ADDR_W = 3
) (
   input  logic              iClock,
   input  logic              iReset_n,
   input  logic              iInstrValid,
   input  logic [15:0]       iInstr,
   output logic              oInstrReady,
   output logic [DATA_W-1:0] oOperandA,
   output logic [DATA_W-1:0] oOperandB,
   output logic [7:0]        oOperation,
   input  logic [DATA_W-1:0] iAluResult,
   output logic              oIllegal,
   output logic              oBusy,
   input  logic [ADDR_W-1:0] iDbgAddr,
   output logic [DATA_W-1:0] oDbgData
);

   typedef struct packed {
      logic [3:0]        opcode;
      logic [ADDR_W-1:0] rd;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      logic [2:0]        lo;
   } instr_t;

   localparam logic [3:0] OP_NOT = 4'd3;
   localparam logic [3:0] OP_LDI = 4'd8;

   instr_t            ins;
   logic [DATA_W-1:0] rf [REGS];

   logic              e1_vld;
   logic [ADDR_W-1:0] e1_rd;
   logic              e2_vld;
   logic [ADDR_W-1:0] e2_rd;

   logic              legal;
   logic              use_ra;
   logic              use_rb;
   logic              hazard;
   logic              accept;
   logic              issue;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] nxt_a;
   logic [DATA_W-1:0] nxt_b;
   logic [7:0]        op_oh;

   assign ins = instr_t'(iInstr);

   always_comb begin
      legal  = (ins.opcode <= OP_LDI);
      use_ra = legal && (ins.opcode != OP_LDI);
      use_rb = use_ra && (ins.opcode != OP_NOT);
      hazard = e1_vld && ((use_ra && (ins.ra == e1_rd)) || (use_rb && (ins.rb == e1_rd)));
   end

   // Ready is held low while in reset so every output reads 0 there.
   assign oInstrReady = iReset_n && !hazard;
   assign accept      = iInstrValid && oInstrReady;
   assign issue       = accept && legal;

   // The E2 result is still in the ALU output register, so it wins over the stale regfile entry.
   always_comb begin
      src_a = (e2_vld && (e2_rd == ins.ra)) ? iAluResult : rf[ins.ra];
      src_b = (e2_vld && (e2_rd == ins.rb)) ? iAluResult : rf[ins.rb];
      if (ins.opcode == OP_LDI) begin
         nxt_a = DATA_W'(ins[7:0]);
         nxt_b = '0;
         op_oh = 8'h04;
      end else begin
         nxt_a = src_a;
         nxt_b = src_b;
         op_oh = 8'b1 << ins.opcode[2:0];
      end
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         e1_vld     <= 1'b0;
         e1_rd      <= '0;
         e2_vld     <= 1'b0;
         e2_rd      <= '0;
         oOperandA  <= '0;
         oOperandB  <= '0;
         oOperation <= 8'h00;
         oIllegal   <= 1'b0;
      end else begin
         e1_vld     <= issue;
         e2_vld     <= e1_vld;
         e2_rd      <= e1_rd;
         oOperation <= issue ? op_oh : 8'h00;
         oIllegal   <= accept && !legal;
         if (issue) begin
            e1_rd     <= ins.rd;
            oOperandA <= nxt_a;
            oOperandB <= nxt_b;
         end
      end
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         for (int i = 0; i < REGS; i++) begin
            rf[i] <= '0;
         end
      end else if (e2_vld) begin
         rf[e2_rd] <= iAluResult;
      end
   end

   assign oBusy    = e1_vld || e2_vld;
   assign oDbgData = rf[iDbgAddr];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: ALU model on the result port, program-order register model with timed
// commits, per-cycle compare on the falling edge, directed cases then randomized traffic.
module tb_alu_issue;

   logic        iClock = 1'b0;
   logic        iReset_n;
   logic        iInstrValid;
   logic [15:0] iInstr;
   logic        oInstrReady;
   logic [15:0] oOperandA;
   logic [15:0] oOperandB;
   logic [7:0]  oOperation;
   logic [15:0] iAluResult;
   logic        oIllegal;
   logic        oBusy;
   logic [2:0]  iDbgAddr;
   logic [15:0] oDbgData;

   int tests = 0;
   int fails = 0;

   alu_issue dut (
      .iClock      (iClock),
      .iReset_n    (iReset_n),
      .iInstrValid (iInstrValid),
      .iInstr      (iInstr),
      .oInstrReady (oInstrReady),
      .oOperandA   (oOperandA),
      .oOperandB   (oOperandB),
      .oOperation  (oOperation),
      .iAluResult  (iAluResult),
      .oIllegal    (oIllegal),
      .oBusy       (oBusy),
      .iDbgAddr    (iDbgAddr),
      .oDbgData    (oDbgData)
   );

   always #5 iClock = ~iClock;

   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [7:0] op);
      case (op)
         8'h01:   return a + b;
         8'h02:   return a & b;
         8'h04:   return a | b;
         8'h08:   return ~a;
         8'h10:   return a ^ b;
         8'h20:   return (b >= 16'd16) ? 16'h0000 : (a << b[3:0]);
         8'h40:   return (b >= 16'd16) ? 16'h0000 : (a >> b[3:0]);
         8'h80:   return (a == b) ? 16'h0001 : 16'h0000;
         default: return 16'h0000;
      endcase
   endfunction

   logic [15:0] alu_res = 16'h0000;
   always @(posedge iClock) alu_res <= alu_f(oOperandA, oOperandB, oOperation);
   assign iAluResult = alu_res;

   // Reference: mreg is the program-order value of every register as soon as an instruction is
   // accepted; committed is what the debug port must show, updated two edges after acceptance.
   typedef struct {
      logic [2:0]  rd;
      logic [15:0] val;
      int          wb;
      int          iss;
   } pend_t;

   pend_t       q[$];
   logic [15:0] mreg[8];
   logic [15:0] committed[8];
   int          cyc = 0;
   bit          acc = 0;
   logic [7:0]  exp_op = 8'h00;
   logic [15:0] exp_a = 16'h0000;
   logic [15:0] exp_b = 16'h0000;
   bit          exp_ill = 0;
   bit          exp_is_not = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stall iff a source is the destination of the instruction accepted at the most recent edge.
   function automatic bit model_ready(input logic [15:0] ins);
      int op;
      op = int'(ins[15:12]);
      if (op > 8) return 1'b1;
      foreach (q[i]) begin
         if (q[i].iss == cyc) begin
            if (op != 8 && ins[8:6] == q[i].rd) return 1'b0;
            if (op != 8 && op != 3 && ins[5:3] == q[i].rd) return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   task automatic model_clear();
      q.delete();
      for (int i = 0; i < 8; i++) begin
         mreg[i] = 16'h0000;
         committed[i] = 16'h0000;
      end
      cyc = 0;
      acc = 0;
      exp_op = 8'h00;
      exp_a = 16'h0000;
      exp_b = 16'h0000;
      exp_ill = 0;
      exp_is_not = 0;
   endtask

   initial begin : model
      int          op;
      logic [15:0] v;
      model_clear();
      forever begin
         @(posedge iClock or negedge iReset_n);
         if (!iReset_n) begin
            model_clear();
         end else begin
            cyc++;
            while (q.size() > 0 && q[0].wb == cyc) begin
               committed[q[0].rd] = q[0].val;
               q.delete(0);
            end
            exp_op = 8'h00;
            exp_ill = 0;
            if (acc) begin
               op = int'(iInstr[15:12]);
               if (op > 8) begin
                  exp_ill = 1;
               end else begin
                  if (op == 8) begin
                     exp_a = {8'h00, iInstr[7:0]};
                     exp_b = 16'h0000;
                     exp_op = 8'h04;
                  end else begin
                     exp_a = mreg[iInstr[8:6]];
                     exp_b = mreg[iInstr[5:3]];
                     exp_op = 8'(1 << op);
                  end
                  exp_is_not = (op == 3);
                  v = alu_f(exp_a, exp_b, exp_op);
                  mreg[iInstr[11:9]] = v;
                  q.push_back('{rd: iInstr[11:9], val: v, wb: cyc + 2, iss: cyc});
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge iClock);
         if (iReset_n) begin
            chk("ready", {31'd0, oInstrReady}, {31'd0, model_ready(iInstr)});
            chk("busy", {31'd0, oBusy}, {31'd0, (q.size() > 0)});
            chk("illegal", {31'd0, oIllegal}, {31'd0, exp_ill});
            chk("operation", {24'd0, oOperation}, {24'd0, exp_op});
            if (exp_op != 8'h00) begin
               chk("operand_a", {16'd0, oOperandA}, {16'd0, exp_a});
               if (!exp_is_not) chk("operand_b", {16'd0, oOperandB}, {16'd0, exp_b});
            end
            chk("dbg_data", {16'd0, oDbgData}, {16'd0, committed[iDbgAddr]});
            acc = iInstrValid && model_ready(iInstr);
         end else begin
            acc = 0;
         end
      end
   end

   function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
      return {op[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000};
   endfunction

   function automatic logic [15:0] ldi(input int rd, input logic [7:0] imm);
      return {4'h8, rd[2:0], 1'b0, imm};
   endfunction

   task automatic send(input logic [15:0] ins, output int stalls);
      bit done;
      done = 0;
      stalls = 0;
      iInstr = ins;
      iInstrValid = 1'b1;
      for (int k = 0; k < 10 && !done; k++) begin
         @(posedge iClock);
         if (acc) done = 1;
         else stalls++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: instr %h not accepted, got %0d stalls, expected at most 9", ins, stalls);
      end
      #1;
      iInstrValid = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(posedge iClock);
      #1;
   endtask

   task automatic check_reg(input int addr, input logic [15:0] exp, input string name);
      iDbgAddr = addr[2:0];
      #1;
      chk(name, {16'd0, oDbgData}, {16'd0, exp});
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_ready"}, {31'd0, oInstrReady}, 32'd0);
      chk({name, "_opa"}, {16'd0, oOperandA}, 32'd0);
      chk({name, "_opb"}, {16'd0, oOperandB}, 32'd0);
      chk({name, "_op"}, {24'd0, oOperation}, 32'd0);
      chk({name, "_illegal"}, {31'd0, oIllegal}, 32'd0);
      chk({name, "_busy"}, {31'd0, oBusy}, 32'd0);
   endtask

   initial begin : stim
      int st;
      int rop;
      iReset_n = 1'b0;
      iInstrValid = 1'b0;
      iInstr = 16'h0000;
      iDbgAddr = 3'd0;
      repeat (3) @(posedge iClock);
      #2;
      check_all_zero("reset");
      iReset_n = 1'b1;
      #1;
      chk("ready_after_reset", {31'd0, oInstrReady}, 32'd1);
      for (int i = 0; i < 8; i++) check_reg(i, 16'h0000, "dbg_after_reset");
      @(posedge iClock);
      #1;

      // Dependent chain: one stall on the ADD, r2 forwarded from the ALU.
      send(ldi(1, 8'h12), st);
      send(ldi(2, 8'h34), st);
      chk("ldi_no_stall", st, 32'd0);
      send(enc(0, 3, 1, 2), st);
      chk("add_stall_cycles", st, 32'd1);
      chk("add_operation", {24'd0, oOperation}, 32'h01);
      chk("add_opa", {16'd0, oOperandA}, 32'h0012);
      chk("add_opb_fwd", {16'd0, oOperandB}, 32'h0034);
      drain();
      check_reg(3, 16'h0046, "add_r3");

      send(ldi(4, 8'h12), st);
      send(enc(7, 5, 1, 4), st);
      drain();
      check_reg(5, 16'h0001, "cmp_equal");
      send(ldi(4, 8'h13), st);
      send(enc(7, 5, 1, 4), st);
      drain();
      check_reg(5, 16'h0000, "cmp_differ");

      // NOT names r6 in its rb field right behind the LDI of r6: must not stall.
      send(ldi(6, 8'd16), st);
      send(enc(3, 0, 1, 6), st);
      chk("not_rb_no_stall", st, 32'd0);
      send(enc(5, 7, 1, 6), st);
      drain();
      check_reg(0, 16'hFFED, "not_r0");
      check_reg(7, 16'h0000, "sl_by_16");
      check_reg(1, 16'h0012, "r1_intact");

      send(16'hF200, st);
      chk("illegal_no_stall", st, 32'd0);
      chk("illegal_pulse", {31'd0, oIllegal}, 32'd1);
      chk("illegal_no_op", {24'd0, oOperation}, 32'h00);
      @(posedge iClock);
      #1;
      chk("illegal_pulse_end", {31'd0, oIllegal}, 32'd0);
      check_reg(1, 16'h0012, "illegal_no_write");

      @(posedge iClock);
      #3;
      iReset_n = 1'b0;
      #1;
      check_all_zero("midcycle_reset");
      chk("midcycle_reset_dbg", {16'd0, oDbgData}, 32'd0);
      #2;
      iReset_n = 1'b1;
      @(posedge iClock);
      #1;

      // Reset one cycle after issuing the ADD: its writeback must never happen.
      send(ldi(1, 8'h12), st);
      send(ldi(2, 8'h34), st);
      send(enc(0, 3, 1, 2), st);
      @(posedge iClock);
      #2;
      iReset_n = 1'b0;
      #1;
      chk("flight_reset_busy", {31'd0, oBusy}, 32'd0);
      chk("flight_reset_op", {24'd0, oOperation}, 32'd0);
      #2;
      iReset_n = 1'b1;
      repeat (3) @(posedge iClock);
      #1;
      check_reg(3, 16'h0000, "flight_reset_r3");
      chk("flight_reset_idle", {31'd0, oBusy}, 32'd0);

      @(posedge iClock);
      #1;
      for (int c = 0; c < 1500; c++) begin
         if (!iInstrValid || acc) begin
            iInstrValid = ($urandom_range(0, 9) < 7);
            rop = ($urandom_range(0, 15) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            iInstr = {rop[3:0], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                      3'($urandom_range(0, 3)), 3'($urandom)};
         end
         iDbgAddr = 3'($urandom_range(0, 7));
         @(posedge iClock);
         #1;
      end
      iInstrValid = 1'b0;
      drain();
      for (int i = 0; i < 8; i++) check_reg(i, committed[i], "final_regs");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
